// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared types and encodings for the multicycle RV32I controller
package rv_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRPC,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_BGEU = 4'b0111,
    ALU_SLT  = 4'b1001,
    ALU_SLL  = 4'b1010,
    ALU_BGE  = 4'b1011,
    ALU_SRL  = 4'b1100,
    ALU_BEQ  = 4'b1101,
    ALU_SRA  = 4'b1110
  } alu_ctrl_t;

  // Which decode table the ALU decoder applies in the current state
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_RTYPE,
    ALUOP_ITYPE,
    ALUOP_BRANCH
  } alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT      = 2'b00;
  localparam logic [1:0] RES_MEM         = 2'b01;
  localparam logic [1:0] RES_ALU         = 2'b10;
  localparam logic [1:0] RES_ALUOUT_LSB0 = 2'b11;

endpackage

// File: rtl/rv_alu_decoder.sv
// rtl/rv_alu_decoder.sv - maps op class, funct3 and funct7b5 to ALU_ctrl, branch invert and illegal flag
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl,
  output logic       branch_inv,
  output logic       illegal
);

  // bne reuses the beq compare and flips the outcome
  assign branch_inv = (funct3 == 3'b001);

  // Table lookup per op class; illegal encodings fall back to add
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (alu_op)
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          3'b000: alu_ctrl = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: begin
            if (alu_op == ALUOP_ITYPE && funct7b5) illegal = 1'b1;
            else                                   alu_ctrl = ALU_SLL;
          end
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: alu_ctrl = ALU_BEQ;
          3'b100:         alu_ctrl = ALU_SLT;
          3'b101:         alu_ctrl = ALU_BGE;
          3'b110:         alu_ctrl = ALU_SLTU;
          3'b111:         alu_ctrl = ALU_BGEU;
          default:        illegal  = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_mc_controller.sv
// rtl/rv_mc_controller.sv - multicycle RV32I main control FSM; RV_CTRL_ILLEGAL_TRAP_EN makes illegal encodings trap until reset
module rv_mc_controller
  import rv_ctrl_pkg::*;
#(
  parameter int RESET_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       alu_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic [3:0] ALU_ctrl,
  output logic       illegal_instr
);

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
  localparam state_t S_ILL_NEXT = S_TRAP;
`else
  localparam state_t S_ILL_NEXT = S_FETCH;
`endif

  localparam logic [3:0] WAIT_LAST = 4'(RESET_WAIT - 1);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  alu_op_t    alu_op;
  logic [3:0] dec_alu_ctrl;
  logic       dec_branch_inv;
  logic       dec_illegal;

  rv_alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .alu_ctrl   (dec_alu_ctrl),
    .branch_inv (dec_branch_inv),
    .illegal    (dec_illegal)
  );

  // State register and post-reset wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == S_RESET) ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  // Pick the decode table used in the execute-type states
  always_comb begin
    case (state)
      S_EXECR:  alu_op = ALUOP_RTYPE;
      S_EXECI:  alu_op = ALUOP_ITYPE;
      S_BRANCH: alu_op = ALUOP_BRANCH;
      default:  alu_op = ALUOP_ADD;
    endcase
  end

  // Per-state datapath controls and next-state selection
  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    result_src    = RES_ALUOUT;
    ALU_ctrl      = ALU_ADD;
    illegal_instr = 1'b0;
    case (state)
      S_RESET: begin
        if (wait_cnt >= WAIT_LAST) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default: begin
            illegal_instr = 1'b1;
            state_next    = S_ILL_NEXT;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = (op == OP_STORE) ? IMM_S : IMM_I;
        state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        ALU_ctrl   = dec_alu_ctrl;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        ALU_ctrl  = dec_alu_ctrl;
        if (dec_illegal) begin
          illegal_instr = 1'b1;
          state_next    = S_ILL_NEXT;
        end else begin
          state_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        ALU_ctrl   = dec_alu_ctrl;
        if (dec_illegal) begin
          illegal_instr = 1'b1;
          state_next    = S_ILL_NEXT;
        end else begin
          pc_write   = alu_flag ^ dec_branch_inv;
          state_next = S_FETCH;
        end
      end
      S_JAL: begin
        pc_write   = 1'b1;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        state_next = S_JALRPC;
      end
      S_JALRPC: begin
        pc_write   = 1'b1;
        result_src = RES_ALUOUT_LSB0;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a  = SRCA_ZERO;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_U;
        state_next = S_ALUWB;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_rv_mc_controller.sv
// tb/tb_rv_mc_controller.sv - randomized self-checking bench for rv_mc_controller against an instruction-level model
module tb_rv_mc_controller;

  localparam int RW = 3;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       alu_flag;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] imm_src;
  logic [1:0] result_src;
  logic [3:0] ALU_ctrl;
  logic       illegal_instr;

  rv_mc_controller #(.RESET_WAIT(RW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .alu_flag      (alu_flag),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_src       (imm_src),
    .result_src    (result_src),
    .ALU_ctrl      (ALU_ctrl),
    .illegal_instr (illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Expected per-cycle output vectors, mem_ready to drive in each cycle, observed vectors
  logic [19:0] exp_q[$];
  bit          mr_q[$];
  logic [19:0] obs_q[$];
  bit          model_trap;

  // Vector layout: {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
  //                 alu_src_a[1:0], alu_src_b[1:0], imm_src[2:0], result_src[1:0], ALU_ctrl[3:0], illegal}
  function automatic logic [19:0] ev(logic mq, logic mw, logic as, logic irw, logic pcw, logic rw,
                                     logic [1:0] a, logic [1:0] b, logic [2:0] imm,
                                     logic [1:0] res, logic [3:0] alu, logic ill);
    return {mq, mw, as, irw, pcw, rw, a, b, imm, res, alu, ill};
  endfunction

  function automatic logic [19:0] obs();
    return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, imm_src, result_src, ALU_ctrl, illegal_instr};
  endfunction

  function automatic void push(bit mr, logic [19:0] e);
    mr_q.push_back(mr);
    exp_q.push_back(e);
  endfunction

  // After an illegal encoding: either a trap that holds, or straight back to fetch
  function automatic void ill_tail();
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) push(1'b1, ev(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,4'b0000,1));
    model_trap = 1'b1;
`else
    push(1'b0, ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,4'b0000,0));
`endif
  endfunction

  // Instruction-level reference: expected outputs for each cycle of one instruction,
  // ending with one fetch cycle of the next instruction held waiting.
  task automatic model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic flag, input int fw, input int mw);
    logic [3:0]  r_tab [8];
    logic [3:0]  b_tab [8];
    logic [19:0] aluwb, memv;
    logic [3:0]  alu;
    logic        legal;
    r_tab = '{4'b0000, 4'b1010, 4'b1001, 4'b0101, 4'b0100, 4'b1100, 4'b0011, 4'b0010};
    b_tab = '{4'b1101, 4'b1101, 4'b0000, 4'b0000, 4'b1001, 4'b1011, 4'b0101, 4'b0111};
    model_trap = 1'b0;
    aluwb = ev(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,4'b0000,0);
    for (int k = 0; k < fw; k++) push(1'b0, ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,4'b0000,0));
    push(1'b1, ev(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b10,4'b0000,0));
    legal = o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    push(1'($urandom), ev(0,0,0,0,0,0,2'b01,2'b01,(o == 7'b1101111) ? 3'b011 : 3'b010,
                          2'b00,4'b0000,!legal));
    if (!legal) begin
      ill_tail();
      return;
    end
    case (o)
      7'b0000011, 7'b0100011: begin
        push(1'($urandom), ev(0,0,0,0,0,0,2'b10,2'b01,(o == 7'b0100011) ? 3'b001 : 3'b000,
                              2'b00,4'b0000,0));
        memv = ev(1,(o == 7'b0100011),1,0,0,0,2'b00,2'b00,3'b000,2'b00,4'b0000,0);
        for (int k = 0; k < mw; k++) push(1'b0, memv);
        push(1'b1, memv);
        if (o == 7'b0000011) push(1'($urandom), ev(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b01,4'b0000,0));
      end
      7'b0110011: begin
        alu = r_tab[f3];
        if (f3 == 3'd0 && f7) alu = 4'b0001;
        if (f3 == 3'd5 && f7) alu = 4'b1110;
        push(1'($urandom), ev(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b00,alu,0));
        push(1'($urandom), aluwb);
      end
      7'b0010011: begin
        if (f3 == 3'd1 && f7) begin
          push(1'($urandom), ev(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,4'b0000,1));
          ill_tail();
          return;
        end
        alu = r_tab[f3];
        if (f3 == 3'd5 && f7) alu = 4'b1110;
        push(1'($urandom), ev(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,alu,0));
        push(1'($urandom), aluwb);
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          push(1'($urandom), ev(0,0,0,0,0,0,2'b10,2'b00,3'b000,2'b00,4'b0000,1));
          ill_tail();
          return;
        end
        push(1'($urandom), ev(0,0,0,0,flag ^ (f3 == 3'd1),0,2'b10,2'b00,3'b000,2'b00,b_tab[f3],0));
      end
      7'b1101111: begin
        push(1'($urandom), ev(0,0,0,0,1,0,2'b01,2'b10,3'b000,2'b00,4'b0000,0));
        push(1'($urandom), aluwb);
      end
      7'b1100111: begin
        push(1'($urandom), ev(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,4'b0000,0));
        push(1'($urandom), ev(0,0,0,0,1,0,2'b01,2'b10,3'b000,2'b11,4'b0000,0));
        push(1'($urandom), aluwb);
      end
      7'b0110111: begin
        push(1'($urandom), ev(0,0,0,0,0,0,2'b11,2'b01,3'b100,2'b00,4'b0000,0));
        push(1'($urandom), aluwb);
      end
      default: begin
        push(1'($urandom), ev(0,0,0,0,0,0,2'b01,2'b01,3'b100,2'b00,4'b0000,0));
        push(1'($urandom), aluwb);
      end
    endcase
    push(1'b0, ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,4'b0000,0));
  endtask

  // Apply one instruction: entered just after a rising edge with the DUT in fetch
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic flag, input int fw, input int mw);
    exp_q.delete();
    mr_q.delete();
    obs_q.delete();
    op = o; funct3 = f3; funct7b5 = f7; alu_flag = flag;
    model(o, f3, f7, flag, fw, mw);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = mr_q[i];
      @(negedge clk);
      obs_q.push_back(obs());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs() !== 20'h0) begin
      $display("FAIL reset_hold got %h want %h", obs(), 20'h0);
      fails++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < RW; i++) begin
      @(negedge clk);
      vectors++;
      if (obs() !== 20'h0) begin
        $display("FAIL reset_wait cyc%0d got %h want %h", i, obs(), 20'h0);
        fails++;
      end
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs() !== ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,4'b0000,0)) begin
      $display("FAIL reset_fetch got %h want %h", obs(), ev(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,4'b0000,0));
      fails++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype_sub();
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL rtype_sub cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
        fails++;
      end
    end
    vectors++;
    if (obs_q[2][4:1] !== 4'b0001 || obs_q[3][14] !== 1'b1 || obs_q[4][19] !== 1'b1) begin
      $display("FAIL rtype_sub_timing alu %b rw %b next_req %b want 0001 1 1",
               obs_q[2][4:1], obs_q[3][14], obs_q[4][19]);
      fails++;
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [3];
    logic       fls [3];
    f3s = '{3'b001, 3'b001, 3'b111};
    fls = '{1'b0, 1'b1, 1'($urandom)};
    for (int t = 0; t < 3; t++) begin
      run_instr(7'b1100011, f3s[t], 1'b0, fls[t], 0, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          $display("FAIL branch%0d cyc%0d got %h want %h", t, i, obs_q[i], exp_q[i]);
          fails++;
        end
      end
      vectors++;
      if (obs_q[2][15] !== ((t == 2) ? fls[t] : !fls[t])) begin
        $display("FAIL branch%0d_pcw got %b flag %b", t, obs_q[2][15], fls[t]);
        fails++;
      end
    end
  endtask

  task automatic test_load_waits();
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL load_wait cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
        fails++;
      end
    end
    vectors++;
    if (obs_q[7][14] !== 1'b1 || obs_q[7][6:5] !== 2'b01) begin
      $display("FAIL load_memwb got rw %b res %b want 1 01", obs_q[7][14], obs_q[7][6:5]);
      fails++;
    end
  endtask

  task automatic test_jalr();
    run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL jalr cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
        fails++;
      end
    end
  endtask

  task automatic test_illegal();
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        $display("FAIL illegal cyc%0d got %h want %h", i, obs_q[i], exp_q[i]);
        fails++;
      end
    end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    vectors++;
    if (illegal_instr !== 1'b1 || mem_req !== 1'b0) begin
      $display("FAIL illegal_trap got ill %b req %b want 1 0", illegal_instr, mem_req);
      fails++;
    end
    test_reset();
`else
    vectors++;
    if (obs_q[2][19] !== 1'b1 || obs_q[2][0] !== 1'b0) begin
      $display("FAIL illegal_refetch got req %b ill %b want 1 0", obs_q[2][19], obs_q[2][0]);
      fails++;
    end
`endif
  endtask

  task automatic test_reset_mid();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || adr_src !== 1'b1) begin
      $display("FAIL midreset_pre got req %b adr %b want 1 1", mem_req, adr_src);
      fails++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== 20'h0) begin
      $display("FAIL midreset_async got %h want %h", obs(), 20'h0);
      fails++;
    end
    @(posedge clk);
    #1;
    test_reset();
  endtask

  task automatic test_back_to_back();
    logic [6:0] pool [12];
    logic [6:0] o;
    pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
             7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000, 7'b0000000};
    for (int n = 0; n < 150; n++) begin
      o = pool[$urandom_range(11)];
      if (n % 12 == 11) o = 7'($urandom);
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(2), $urandom_range(2));
      for (int i = 0; i < obs_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          $display("FAIL b2b n%0d op %b f3 %b cyc%0d got %h want %h",
                   n, op, funct3, i, obs_q[i], exp_q[i]);
          fails++;
        end
      end
      if (model_trap) test_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    alu_flag = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype_sub();
    test_branch();
    test_load_waits();
    test_jalr();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
